sram_rw_port_arbiter: RTL and testbench
=======================================

Name: sram_rw_port_arbiter

Overview:
- Shares the single RW port (port 0) of the 32x256 OpenRAM data SRAM between two requesters.
  - Requester 0: core load/store unit.
  - Requester 1: loader/debug master.
- Arbitrates one access per cycle and drives the macro's csb0/web0/wmask0/addr0/din0 pins.
- Captures dout0 and returns read data to the originating requester with a fixed latency.
- Optional post-reset zero-fill FSM clears the array before any requester is granted.

Parameters:
- ADDR_WIDTH, 8, SRAM word address width.
- DATA_WIDTH, 32, SRAM word width.
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8).
- CLEAR_ON_RESET, 0, 1 = zero-fill all 2^ADDR_WIDTH words after reset before granting.
- FIXED_PRIORITY, 0, 1 = requester 1 always wins; 0 = round-robin.

Ports:
- clk, in, 1, single clock; also drives SRAM clk0 at top level.
- rst_n, in, 1, asynchronous active-low reset.
- rq_valid[1:0], in, 2, request valid per requester.
- rq_ready[1:0], out, 2, request accepted this cycle.
- rq_we[1:0], in, 2, 1 = write.
- rq_wmask, in, 2*NUM_WMASKS, byte mask; requester r uses slice r.
- rq_addr, in, 2*ADDR_WIDTH, word address per requester.
- rq_wdata, in, 2*DATA_WIDTH, write data per requester.
- rsp_valid[1:0], out, 2, read data valid for requester r.
- rsp_rdata, out, DATA_WIDTH, read data (shared bus; qualified by rsp_valid).
- init_done, out, 1, high once the clear sequence has finished, or immediately if CLEAR_ON_RESET=0.
- sram_csb0, out, 1, SRAM chip select, active low.
- sram_web0, out, 1, SRAM write enable, active low.
- sram_wmask0, out, NUM_WMASKS, SRAM byte mask.
- sram_addr0, out, ADDR_WIDTH, SRAM address.
- sram_din0, out, DATA_WIDTH, SRAM write data.
- sram_dout0, in, DATA_WIDTH, SRAM read data.

Behaviour:
- Reset values:
  - rq_ready=0, rsp_valid=0, rsp_rdata=0.
  - sram_csb0=1, sram_web0=1, wmask0/addr0/din0=0.
  - init_done=0 if CLEAR_ON_RESET=1, else 1.
  - RR pointer = requester 0; clear counter = 0.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR:
  - rq_ready=0.
  - Each cycle drives csb0=0, web0=0, wmask0=all ones, din0=0, addr0=counter.
  - Counter increments each cycle. After addr 2^ADDR_WIDTH-1 is written, the next cycle is RUN and init_done=1.
  - Duration is exactly 256 cycles at default parameters.
  - Requests presented during CLEAR are held off, not dropped.
- RUN arbitration (combinational within the cycle):
  - Grant goes to at most one valid requester; rq_ready[g]=1 for the granted requester only.
  - SRAM pins are driven combinationally from the granted request, so the macro samples them at the same posedge that completes the handshake (cycle T).
  - With no grant: csb0=1; addr0/din0/wmask0 hold their previous values.
- Round-robin (FIXED_PRIORITY=0):
  - When both requesters are valid, the one not granted last wins.
  - The pointer updates only on a grant.
  - A lone valid requester is granted every cycle (no bubble).
- Write handling: web0=0, wmask0=rq_wmask slice. No response is generated.
- Read handling:
  - web0=1; a pipeline tag {valid, requester id} is registered at T.
  - dout0 is valid between negedge T and posedge T+1. It is captured into rsp_rdata at posedge T+1.
  - rsp_valid[id]=1 during cycle T+1 to T+2, i.e. a one-cycle pulse.
  - Read latency is 2 edges from accept to data registered.
- Throughput: one access per cycle. Back-to-back reads produce back-to-back rsp_valid pulses.
- Ordering:
  - A write at T followed by a read of the same address at T+1 returns the new data, because the macro writes at negedge T.
  - Responses have no backpressure; requesters must accept rsp_valid unconditionally.
- rsp_rdata holds its last captured value when rsp_valid=0.
- Reset asserted mid-operation:
  - The in-flight read tag is cleared and no rsp_valid is issued.
  - A CLEAR sequence restarts from address 0.

Decomposition:
- Package sram_arb_pkg:
  - Constants NUM_REQ=2, SRAM_DEPTH=256.
  - State enum {ST_CLEAR, ST_RUN}.
  - Request struct {we, wmask, addr, wdata}.
- One sub-module, rr_arbiter2: a 2-way round-robin/fixed-priority grant with pointer register, reusable elsewhere.
- The clear FSM, SRAM pin mux and response pipeline stay in the top module.
- Benches pair the block with the SRAM behavioural model for checking.

Test Plan:
- CLEAR_ON_RESET=1, release reset, rq_valid=2'b11:
  - rq_ready stays 0 for 256 cycles and init_done rises on cycle 256.
  - Subsequent reads of addr 0x00, 0x7F and 0xFF return 0x00000000.
- Requester 0 writes 0xDEADBEEF with mask 4'b1111 to 0x10; next cycle it reads 0x10:
  - rsp_valid[0] pulses 2 edges after the read accept with rdata=0xDEADBEEF.
  - rsp_valid[1] stays 0.
- Byte mask: write 0x11223344 with mask 4'b0101 over 0xDEADBEEF at 0x20, then read 0x20 -> 0xDE22BE44.
- Both requesters hold valid reads to 0x01/0x02 for 6 cycles with FIXED_PRIORITY=0:
  - Grants alternate 0,1,0,1,0,1.
  - Responses arrive in grant order with the matching ids.
  - With FIXED_PRIORITY=1, requester 1 is granted all 6 cycles.
- Assert rst_n low one cycle after a read accept: no rsp_valid occurs, and all outputs take reset values immediately (asynchronously).
- Idle cycles with no valid requests: sram_csb0=1 throughout and rsp_valid stays 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM RW-port arbiter.
package sram_arb_pkg;

  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned SRAM_DEPTH     = 256;

  // Request fields are sized for the widest supported macro; narrower
  // instances zero-extend into them.
  localparam int unsigned MAX_ADDR_WIDTH = 16;
  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_WMASKS     = 8;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } arb_state_e;

  typedef struct packed {
    logic                      we;
    logic [MAX_WMASKS-1:0]     wmask;
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic [MAX_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin with a last-grant pointer, or fixed priority
// to requester 1. Grants are combinational; the pointer moves only on a grant.
module rr_arbiter2 #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the requester that wins a tie.
  logic       ptr_q, ptr_d;
  logic [1:0] req;

  always_comb begin
    req   = req_i & {2{en_i}};
    gnt_o = '0;
    if (FIXED_PRIORITY != 0) begin
      if (req[1]) begin
        gnt_o = 2'b10;
      end else if (req[0]) begin
        gnt_o = 2'b01;
      end
    end else if (req == 2'b11) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req;
    end
    ptr_d = (gnt_o != '0) ? gnt_o[0] : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// Shares the OpenRAM RW port between the LSU (req 0) and the loader/debug
// master (req 1), with an optional post-reset zero-fill of the array.
module sram_rw_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WMASKS     = 4,
  parameter int unsigned CLEAR_ON_RESET = 0,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            rq_valid,
  output logic [NUM_REQ-1:0]            rq_ready,
  input  logic [NUM_REQ-1:0]            rq_we,
  input  logic [NUM_REQ*NUM_WMASKS-1:0] rq_wmask,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          init_done,
  output logic                          sram_csb0,
  output logic                          sram_web0,
  output logic [NUM_WMASKS-1:0]         sram_wmask0,
  output logic [ADDR_WIDTH-1:0]         sram_addr0,
  output logic [DATA_WIDTH-1:0]         sram_din0,
  input  logic [DATA_WIDTH-1:0]         sram_dout0
);

  arb_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     clr_cnt_q, clr_cnt_d;

  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     din_q;
  logic [NUM_WMASKS-1:0]     wmask_q;

  logic                      tag_vld_q, tag_vld_d;
  logic                      tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

  sram_req_t                 req [NUM_REQ];
  sram_req_t                 sel;
  logic [NUM_REQ-1:0]        gnt;
  logic                      gnt_id;
  logic                      arb_en;
  logic                      unused_sel;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req[r]                        = '0;
      req[r].we                     = rq_we[r];
      req[r].wmask[NUM_WMASKS-1:0]  = rq_wmask[r*NUM_WMASKS +: NUM_WMASKS];
      req[r].addr[ADDR_WIDTH-1:0]   = rq_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      req[r].wdata[DATA_WIDTH-1:0]  = rq_wdata[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Handshake and pin drive are combinational, so they are gated by rst_n
  // to give reset-value outputs while reset is held.
  assign arb_en = rst_n && (state_q == ST_RUN);

  rr_arbiter2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_arb (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (arb_en),
    .req_i (rq_valid),
    .gnt_o (gnt)
  );

  assign gnt_id     = gnt[1];
  assign sel        = req[gnt_id];
  assign unused_sel = ^sel;
  assign rq_ready   = gnt;
  assign init_done  = (state_q == ST_RUN);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

  // SRAM pin mux: clear sweep, granted request, or idle with held pins.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = wmask_q;
    sram_addr0  = addr_q;
    sram_din0   = din_q;
    if (rst_n && (state_q == ST_CLEAR)) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = clr_cnt_q;
      sram_din0   = '0;
    end else if (gnt != '0) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~sel.we;
      sram_wmask0 = sel.wmask[NUM_WMASKS-1:0];
      sram_addr0  = sel.addr[ADDR_WIDTH-1:0];
      sram_din0   = sel.wdata[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  // Read tag is taken at the accept edge; the macro drives dout0 by the
  // following negedge, so data and the valid pulse register one edge later.
  always_comb begin
    tag_vld_d   = (gnt != '0) && !sel.we;
    tag_id_d    = gnt_id;
    rsp_valid_d = tag_vld_q ? {tag_id_q, ~tag_id_q} : '0;
    rsp_rdata_d = tag_vld_q ? sram_dout0 : rsp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      wmask_q     <= '0;
      tag_vld_q   <= 1'b0;
      tag_id_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      if (!sram_csb0) begin
        addr_q  <= sram_addr0;
        din_q   <= sram_din0;
        wmask_q <= sram_wmask0;
      end
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Bench for sram_rw_port_arbiter: round-robin/clear instance paired with an
// OpenRAM-style SRAM model, plus a fixed-priority no-clear instance.
`timescale 1ns/1ps
module tb_sram_rw_port_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rq_valid, rq_ready, rq_we, rsp_valid;
  logic [7:0]  rq_wmask;
  logic [15:0] rq_addr;
  logic [63:0] rq_wdata;
  logic [31:0] rsp_rdata, sram_din0, sram_dout0;
  logic        init_done, sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;

  logic [1:0]  fp_rq_ready, fp_rsp_valid;
  logic [31:0] fp_rsp_rdata, fp_sram_din0;
  logic        fp_init_done, fp_sram_csb0, fp_sram_web0;
  logic [3:0]  fp_sram_wmask0;
  logic [7:0]  fp_sram_addr0;

  always #5 clk = ~clk;

  sram_rw_port_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4),
    .CLEAR_ON_RESET(1), .FIXED_PRIORITY(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_we(rq_we), .rq_wmask(rq_wmask), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  sram_rw_port_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WMASKS(4),
    .CLEAR_ON_RESET(0), .FIXED_PRIORITY(1)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_ready(fp_rq_ready),
    .rq_we(rq_we), .rq_wmask(rq_wmask), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata), .init_done(fp_init_done),
    .sram_csb0(fp_sram_csb0), .sram_web0(fp_sram_web0), .sram_wmask0(fp_sram_wmask0),
    .sram_addr0(fp_sram_addr0), .sram_din0(fp_sram_din0), .sram_dout0(32'h0)
  );

  // OpenRAM-style macro: pins sampled at posedge, array accessed at negedge.
  logic [31:0] mem [SRAM_DEPTH];
  logic        m_csb = 1'b1, m_web = 1'b1;
  logic [3:0]  m_wm;
  logic [7:0]  m_a;
  logic [31:0] m_d;
  bit          seeded = 1'b0;

  always @(posedge clk) begin
    m_csb <= sram_csb0;
    m_web <= sram_web0;
    m_wm  <= sram_wmask0;
    m_a   <= sram_addr0;
    m_d   <= sram_din0;
  end

  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < SRAM_DEPTH; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      seeded = 1'b1;
    end
    if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < 4; b++) if (m_wm[b]) mem[m_a][8*b +: 8] = m_d[8*b +: 8];
      end else begin
        sram_dout0 <= mem[m_a];
      end
    end
  end

  // Reference model state.
  int          nvec, nfail;
  logic [1:0]  v_r, we_r;
  logic [3:0]  wm_r [2];
  logic [7:0]  a_r  [2];
  logic [31:0] d_r  [2];
  logic [31:0] gold [SRAM_DEPTH];
  int          clr_left;
  logic        last_id;
  logic [1:0]  s1_v, s2_v, last_eg;
  logic [31:0] s1_d, s2_d, exp_rdata;
  logic [7:0]  last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic w, input logic [3:0] m,
                         input logic [7:0] a, input logic [31:0] d);
    v_r[r] = v; we_r[r] = w; wm_r[r] = m; a_r[r] = a; d_r[r] = d;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rq_ready", 32'(rq_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_csb_web", 32'({sram_csb0, sram_web0}), 32'h3);
    chk("rst_wmask_addr", 32'({sram_wmask0, sram_addr0}), 32'h0);
    chk("rst_din", sram_din0, 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_fp_init_done", 32'(fp_init_done), 32'h1);
    chk("rst_fp_ready_csb", 32'({fp_rq_ready, fp_sram_csb0}), 32'h1);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    clr_left = SRAM_DEPTH;
    last_id = 1'b1;          // requester 0 wins the first tie
    s1_v = '0; s2_v = '0; s1_d = '0; s2_d = '0;
    exp_rdata = '0; last_addr = '0; last_eg = '0;
    for (int i = 0; i < SRAM_DEPTH; i++) gold[i] = '0;
  endtask

  // One clock: called at a negedge, checks responses, drives, checks the grant.
  task automatic step();
    logic [1:0]  eg, nv;
    logic [31:0] nd;
    bit          in_clear;
    int          g;
    if (s2_v != 2'b00) exp_rdata = s2_d;
    chk("rsp_valid", 32'(rsp_valid), 32'(s2_v));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    rq_valid = v_r;
    rq_we    = we_r;
    rq_wmask = {wm_r[1], wm_r[0]};
    rq_addr  = {a_r[1], a_r[0]};
    rq_wdata = {d_r[1], d_r[0]};
    #1;
    eg = '0; nv = '0; nd = '0;
    in_clear = (clr_left > 0);
    if (in_clear) begin
      chk("clr_init_done", 32'(init_done), 32'h0);
      chk("clr_addr", 32'(sram_addr0), 32'(SRAM_DEPTH - clr_left));
      chk("clr_ctl", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'h0F);
      chk("clr_din", sram_din0, 32'h0);
      last_addr = 8'(SRAM_DEPTH - clr_left);
      clr_left--;
    end else begin
      chk("init_done", 32'(init_done), 32'h1);
      if (v_r == 2'b11) eg = last_id ? 2'b01 : 2'b10;
      else eg = v_r;
    end
    chk("rq_ready", 32'(rq_ready), 32'(eg));
    chk("fp_rq_ready", 32'(fp_rq_ready), (v_r == 2'b11) ? 32'h2 : 32'(v_r));
    if (eg != '0) begin
      g = eg[1] ? 1 : 0;
      chk("csb0", 32'(sram_csb0), 32'h0);
      chk("addr0", 32'(sram_addr0), 32'(a_r[g]));
      chk("web0", 32'(sram_web0), 32'(!we_r[g]));
      if (we_r[g]) begin
        chk("wmask0", 32'(sram_wmask0), 32'(wm_r[g]));
        chk("din0", sram_din0, d_r[g]);
        for (int b = 0; b < 4; b++) if (wm_r[g][b]) gold[a_r[g]][8*b +: 8] = d_r[g][8*b +: 8];
      end else begin
        nv = eg;
        nd = gold[a_r[g]];
      end
      last_id = eg[1];
      last_addr = a_r[g];
    end else if (!in_clear) begin
      chk("idle_csb0", 32'(sram_csb0), 32'h1);
      chk("idle_addr_hold", 32'(sram_addr0), 32'(last_addr));
    end
    last_eg = eg;
    s2_v = s1_v; s2_d = s1_d;
    s1_v = nv;   s1_d = nd;
    @(negedge clk);
  endtask

  initial begin
    nvec = 0; nfail = 0;
    rst_n = 1'b0;
    v_r = '0; we_r = '0;
    for (int r = 0; r < 2; r++) begin wm_r[r] = '0; a_r[r] = '0; d_r[r] = '0; end
    rq_valid = 2'b11; rq_we = '0; rq_wmask = '0; rq_addr = '0; rq_wdata = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_vals();

    // Clear sweep with both requesters waiting, then read back zeros.
    release_reset();
    set_req(0, 1, 0, 4'hF, 8'h00, '0);
    set_req(1, 1, 0, 4'hF, 8'h7F, '0);
    repeat (SRAM_DEPTH) step();
    step();
    set_req(0, 1, 0, 4'hF, 8'hFF, '0);
    step();
    v_r[1] = 1'b0;
    step();
    v_r = '0;
    repeat (2) step();

    // Write then read-after-write at the next cycle.
    set_req(0, 1, 1, 4'hF, 8'h10, 32'hDEADBEEF);
    step();
    set_req(0, 1, 0, 4'hF, 8'h10, '0);
    step();
    v_r = '0;
    repeat (2) step();
    chk("rdata_10", rsp_rdata, 32'hDEADBEEF);

    // Partial byte-mask write.
    set_req(0, 1, 1, 4'hF, 8'h20, 32'hDEADBEEF);
    step();
    set_req(0, 1, 1, 4'b0101, 8'h20, 32'h11223344);
    step();
    set_req(0, 1, 0, 4'hF, 8'h20, '0);
    step();
    v_r = '0;
    repeat (2) step();
    chk("rdata_20_mask", rsp_rdata, 32'hDE22BE44);

    // Contended reads: seed 0x01/0x02, leave requester 1 as last winner.
    set_req(0, 1, 1, 4'hF, 8'h01, 32'h0101_0101);
    step();
    set_req(0, 0, 0, 4'hF, 8'h01, '0);
    set_req(1, 1, 1, 4'hF, 8'h02, 32'h0202_0202);
    step();
    set_req(0, 1, 0, 4'hF, 8'h01, '0);
    set_req(1, 1, 0, 4'hF, 8'h02, '0);
    repeat (6) step();
    v_r = '0;
    repeat (2) step();

    // Reset one cycle after a read accept: response must never appear.
    set_req(0, 1, 0, 4'hF, 8'h10, '0);
    step();
    rq_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("rst_hold_rsp_valid2", 32'(rsp_valid), 32'h0);
    v_r = '0;
    release_reset();
    repeat (SRAM_DEPTH) step();
    repeat (8) step();

    // Randomized traffic; a request is held until granted.
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(v_r[r] && !last_eg[r])) begin
          v_r[r]  = ($urandom_range(0, 3) != 0);
          we_r[r] = 1'($urandom_range(0, 1));
          wm_r[r] = 4'($urandom);
          a_r[r]  = 8'($urandom_range(0, 15));
          d_r[r]  = $urandom;
        end
      end
      step();
    end
    v_r = '0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
